// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-8 helpers for the ccff chain loader.
// Serial CRC is MSB-shift form over one bit per step.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic       din
  );
    logic fb;
    fb = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial 1-bit CRC-8 accumulator with clear and enable.
// Clear wins over enable.
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams a word bitstream into a ccff chain, then optionally
// rotates it once to compare readback CRC against write CRC.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int VERIFY    = 1
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN_LEN - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORD_W - 1);

  state_t state, state_nxt;

  logic [WORD_W-1:0] word_q;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     wbit_cnt;
  logic              err_q;
  logic [7:0]        wr_crc;
  logic [7:0]        rd_crc;
  logic [7:0]        rd_nxt;
  logic              last_bit;
  logic              word_end;
  logic              go;

  assign last_bit = (bit_cnt == BIT_LAST);
  assign word_end = (wbit_cnt == WORD_LAST);
  assign go       = (state == S_IDLE) && start;
  assign rd_nxt   = crc8_step(rd_crc, ccff_tail);

  always_ff @(posedge prog_clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (cfg_valid) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (last_bit)
          state_nxt = (VERIFY != 0) ? S_VERIFY : S_DONE;
        else if (word_end)
          state_nxt = S_FETCH;
      end
      S_VERIFY: if (last_bit) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // bit_cnt is reused as the rotation counter once loading ends
  always_ff @(posedge prog_clk) begin
    if (!reset) begin
      word_q   <= '0;
      bit_cnt  <= '0;
      wbit_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            bit_cnt  <= '0;
            wbit_cnt <= '0;
            err_q    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (cfg_valid) begin
            word_q   <= cfg_data;
            wbit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          word_q   <= word_q >> 1;
          wbit_cnt <= wbit_cnt + 1'b1;
          bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
        end
        S_VERIFY: begin
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          if (last_bit && (rd_nxt != wr_crc))
            err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  ccff_crc8 u_wr_crc (
    .clk   (prog_clk),
    .rst_n (reset),
    .clr   (go),
    .en    (state == S_SHIFT),
    .din   (word_q[0]),
    .crc   (wr_crc)
  );

  ccff_crc8 u_rd_crc (
    .clk   (prog_clk),
    .rst_n (reset),
    .clr   (go),
    .en    (state == S_VERIFY),
    .din   (ccff_tail),
    .crc   (rd_crc)
  );

  assign cfg_ready   = (state == S_FETCH);
  assign ccff_clk_en = (state == S_SHIFT) || (state == S_VERIFY);
  assign ccff_head   = (state == S_SHIFT)  ? word_q[0] :
                       (state == S_VERIFY) ? ccff_tail : 1'b0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign err         = err_q;

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, giving the number of configuration flops in the target ccff chain (range 2..4096).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width (range 1..32).
REQ-003 SHALL have parameter VERIFY, default 1; when 1, a readback rotation and CRC check follows loading.
REQ-004 prog_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-007 cfg_data  input  WORD_W  bitstream word; LSB shifted first.
REQ-008 cfg_valid  input  1  cfg_data valid.
REQ-009 cfg_ready  output  1  loader accepts a word this cycle.
REQ-010 ccff_head  output  1  serial data into the chain head.
REQ-011 ccff_clk_en  output  1  enable for the external prog_clk gate feeding the chain; one chain shift per high cycle.
REQ-012 ccff_tail  input  1  serial data from the chain tail.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  sticky readback CRC mismatch flag.

Function
REQ-016 States SHALL be IDLE, FETCH, SHIFT, VERIFY, DONE.
REQ-017 IDLE: start=1 -> FETCH; clear err, bit counter and both CRCs.
REQ-018 FETCH: cfg_ready=1; on cfg_valid&cfg_ready latch word -> SHIFT; cfg_valid=0 stalls with ccff_clk_en=0.
REQ-019 SHIFT: ccff_clk_en=1 and ccff_head = current word bit (bit 0 first); exactly one bit per cycle.
REQ-020 SHIFT leaves after min(WORD_W, bits remaining) cycles: to FETCH if total bits shifted < CHAIN_LEN, else to VERIFY (VERIFY=1) or DONE (VERIFY=0).
REQ-021 Number of words consumed SHALL be ceil(CHAIN_LEN/WORD_W); unused upper bits of the final word are discarded, never shifted.
REQ-022 Every bit driven on ccff_head in SHIFT SHALL update the write CRC-8 (poly 0x07, init 0x00, serial, MSB-shift form).
REQ-023 VERIFY: ccff_clk_en=1, ccff_head = ccff_tail (combinational rotation), for exactly CHAIN_LEN cycles; each sampled ccff_tail SHALL update the read CRC-8; chain contents are restored on exit.
REQ-024 On VERIFY exit, err SHALL be set if read CRC != write CRC; state -> DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 ccff_clk_en SHALL be 0 in IDLE, FETCH and DONE.
REQ-027 start while busy SHALL be ignored.
REQ-028 cfg_ready SHALL be 0 outside FETCH; cfg_valid outside FETCH SHALL be ignored.
REQ-029 err SHALL hold until the next accepted start or reset.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE from any state, including mid-SHIFT/VERIFY.
REQ-031 Reset values: cfg_ready=0, ccff_head=0, ccff_clk_en=0, busy=0, done=0, err=0; counters and CRCs zero.
REQ-032 Chain contents after a mid-operation reset are undefined; no recovery is attempted.

Structure
REQ-033 Package ccff_loader_pkg SHALL hold the state enum, CRC8_POLY (0x07) and CRC8_INIT (0x00) constants.
REQ-034 One sub-module ccff_crc8 (serial 1-bit CRC-8, clear/enable inputs) SHALL be instantiated twice (write and read).
REQ-035 Bit/word counters SHALL be sized $clog2(CHAIN_LEN+1) and $clog2(WORD_W+1).

Verification
REQ-036 CHAIN_LEN=16, WORD_W=8, cfg_valid held, words 0xA5,0x3C, start in cycle 0 -> cfg_ready cycles 1 and 10, ccff_clk_en cycles 2-9, 11-34, chain model = 16'h3CA5 (first bit at tail), done in cycle 35, err=0.
REQ-037 Same words, cfg_valid deasserted 5 cycles before second word -> ccff_clk_en low throughout stall, final chain 16'h3CA5, done 5 cycles later.
REQ-038 Chain model flips one bit during VERIFY -> done with err=1; err stays 1 until next start, then clears.
REQ-039 CHAIN_LEN=13, words 0xFF, 0x1F -> exactly 13 shifts in SHIFT, 13 in VERIFY, bits 5-7 of second word never driven, err=0.
REQ-040 reset=0 mid-SHIFT -> next cycle all outputs at reset values; a subsequent start completes a normal load.
REQ-041 start pulsed during SHIFT and VERIFY -> no effect on state, counts or done timing.
